// File: rtl/stage_if_pkg.sv
// stage_if_pkg: shared fetch-path widths, NOP encoding and reset vector
package stage_if_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0] inst_t;
  localparam inst_t NOP = 32'h0000_0013;
  localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/stage_if_if.sv
// stage_if_if: instruction-memory read bus between the fetch stage and memory
interface stage_if_if;
  import stage_if_pkg::*;
  logic       mem_req;
  inst_addr_t mem_addr;
  logic       mem_ready;
  inst_t      mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage with redirect handling and a one-entry skid buffer
module stage_if
  import stage_if_pkg::*;
#(
  parameter inst_addr_t RESET_PC = RESET_PC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       br,
  input  inst_addr_t br_addr,
  stage_if_if.master mem,
  output inst_addr_t if_pc,
  output inst_t      if_inst,
  output logic       if_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t     state;
  inst_addr_t pc, buf_pc, redirect_pc;
  inst_t      buf_inst;
  logic       redirect_pending, take_br, kill, deliver;
  assign take_br = br && !stall;
  assign kill = redirect_pending || take_br;
  assign deliver = mem.mem_ready && !kill && !stall;
  assign mem.mem_req = state == FETCH && !rst;
  assign mem.mem_addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      if_pc <= '0;
      if_inst <= NOP;
      if_valid <= 1'b0;
      redirect_pending <= 1'b0;
      redirect_pc <= '0;
      buf_inst <= NOP;
      buf_pc <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          // a word returning under a pending or fresh redirect is dropped
          if (mem.mem_ready && kill) begin
            pc <= take_br ? br_addr : redirect_pc;
            redirect_pending <= 1'b0;
          end else if (mem.mem_ready && stall) begin
            buf_inst <= mem.mem_rdata;
            buf_pc <= pc;
            pc <= pc + 32'd4;
            state <= HOLD;
          end else if (deliver) begin
            if_pc <= pc;
            pc <= pc + 32'd4;
          end else if (take_br) begin
            redirect_pending <= 1'b1;
            redirect_pc <= br_addr;
          end
          if (!stall) begin
            if_inst <= deliver ? mem.mem_rdata : NOP;
            if_valid <= deliver;
          end
        end
        HOLD: if (!stall) begin
          state <= FETCH;
          pc <= br ? br_addr : pc;
          if_pc <= br ? if_pc : buf_pc;
          if_inst <= br ? NOP : buf_inst;
          if_valid <= !br;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed scenarios plus randomized traffic against a transaction-level fetch model
module tb_stage_if;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst, stall, br;
  logic [31:0] br_addr, if_pc, if_inst;
  logic        if_valid;
  int          n_chk = 0, n_fail = 0;
  stage_if_if bus();
  stage_if #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br(br), .br_addr(br_addr),
    .mem(bus), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );
  always #5 clk = ~clk;
  bit          m_run, m_buf, m_redir, e_valid;
  logic [31:0] m_pc, m_bpc, m_binst, m_rpc, e_pc, e_inst;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // m_run: past the post-reset idle cycle; m_buf: a fetched word is parked; m_redir: target owed
  task automatic model_step(input bit r, s, b, input logic [31:0] ba, input bit rdy, input logic [31:0] rd);
    bit take, kill;
    take = b && !s;
    if (r) begin
      m_run = 0; m_buf = 0; m_redir = 0; m_pc = RESET_PC;
      e_pc = 0; e_inst = NOP_W; e_valid = 0;
    end else if (!m_run) m_run = 1;
    else if (m_buf) begin
      if (!s) begin
        m_buf = 0;
        if (b) begin m_pc = ba; e_inst = NOP_W; e_valid = 0; end
        else begin e_pc = m_bpc; e_inst = m_binst; e_valid = 1; end
      end
    end else begin
      kill = m_redir || take;
      if (rdy && kill) begin m_pc = take ? ba : m_rpc; m_redir = 0; end
      else if (rdy && s) begin m_bpc = m_pc; m_binst = rd; m_pc = m_pc + 4; m_buf = 1; end
      else if (rdy) begin e_pc = m_pc; e_inst = rd; e_valid = 1; m_pc = m_pc + 4; end
      else if (take) begin m_redir = 1; m_rpc = ba; end
      if (!s && !(rdy && !kill)) begin e_inst = NOP_W; e_valid = 0; end
    end
  endtask
  task automatic cyc(input bit r, s, b, input logic [31:0] ba, input bit rdy);
    logic [31:0] rd;
    @(negedge clk);
    check("if_pc", if_pc, e_pc);
    check("if_inst", if_inst, e_inst);
    check("if_valid", if_valid, e_valid);
    check("mem_req", bus.mem_req, !rst && m_run && !m_buf);
    if (!rst && m_run && !m_buf) check("mem_addr", bus.mem_addr, m_pc);
    rd = rdy ? word_of(m_pc) : $urandom;
    rst = r; stall = s; br = b; br_addr = ba;
    bus.mem_ready = rdy; bus.mem_rdata = rd;
    #1;
    if (r) check("req_in_rst", bus.mem_req, 0);
    model_step(r, s, b, ba, rdy, rd);
  endtask
  initial begin
    rst = 1; stall = 0; br = 0; br_addr = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    model_step(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    check("s1_pc0", if_pc, 32'h0); check("s1_inst0", if_inst, word_of(32'h0)); check("s1_valid", if_valid, 1);
    cyc(0, 0, 0, 0, 1); check("s1_pc4", if_pc, 32'h4);
    cyc(0, 0, 0, 0, 1); check("s1_pc8", if_pc, 32'h8);
    cyc(0, 0, 0, 0, 0); check("s2_addr_w1", bus.mem_addr, 32'h10);
    cyc(0, 0, 0, 0, 0); check("s2_addr_w2", bus.mem_addr, 32'h10); check("s2_bubble", if_valid, 0);
    cyc(0, 0, 0, 0, 0); check("s2_addr_w3", bus.mem_addr, 32'h10);
    cyc(0, 0, 0, 0, 1); check("s2_addr_w4", bus.mem_addr, 32'h10);
    cyc(0, 0, 0, 0, 1); check("s2_pc", if_pc, 32'h10); check("s2_inst", if_inst, word_of(32'h10)); check("s2_valid", if_valid, 1);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1); check("s3_addr", bus.mem_addr, 32'h20);
    cyc(0, 1, 0, 0, 1); check("s3_hold_pc", if_pc, 32'h1C); check("s3_hold_req", bus.mem_req, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); check("s3_pc", if_pc, 32'h20); check("s3_valid", if_valid, 1); check("s3_next", bus.mem_addr, 32'h24);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h100, 0); check("s4_addr", bus.mem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0); check("s4_bub1", if_valid, 0);
    cyc(0, 0, 0, 0, 1); check("s4_bub2", if_valid, 0); check("s4_addr_held", bus.mem_addr, 32'h8);
    cyc(0, 0, 0, 0, 1); check("s4_target", bus.mem_addr, 32'h100); check("s4_bub3", if_valid, 0);
    cyc(0, 0, 1, 32'h40, 1); check("s4_pc", if_pc, 32'h100); check("s4_inst", if_inst, word_of(32'h100)); check("s4_valid", if_valid, 1);
    cyc(0, 0, 0, 0, 1); check("s5_target", bus.mem_addr, 32'h40); check("s5_bubble", if_valid, 0);
    cyc(0, 0, 0, 0, 0); check("s5_pc", if_pc, 32'h40); check("s5_valid", if_valid, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1); check("s6_req_rst", bus.mem_req, 0);
    cyc(0, 0, 0, 0, 0);
    check("s6_pc", if_pc, 0); check("s6_inst", if_inst, NOP_W); check("s6_valid", if_valid, 0); check("s6_idle_req", bus.mem_req, 0);
    cyc(0, 0, 0, 0, 0); check("s6_req", bus.mem_req, 1); check("s6_addr", bus.mem_addr, RESET_PC);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 0, 1); check("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0); check("wrap_pc", if_pc, 32'hFFFF_FFFC); check("wrap_next", bus.mem_addr, 32'h0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 6);
    cyc(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  pipeline freeze from ctrl; the IF/ID output registers hold while it is high.
REQ-005 br  in  1  redirect request from decode for the instruction currently in if_inst.
REQ-006 br_addr  in  32  redirect target; valid when br=1.
REQ-007 mem_req  out  1  instruction-memory read request.
REQ-008 mem_addr  out  32  read address; held stable while mem_req=1 and mem_ready=0.
REQ-009 mem_ready  in  1  read completes this cycle.
REQ-010 mem_rdata  in  32  instruction word; valid only when mem_ready=1.
REQ-011 if_pc  out  32  registered PC of if_inst.
REQ-012 if_inst  out  32  registered instruction to decode.
REQ-013 if_valid  out  1  if_inst holds a real, non-squashed instruction.

Function
REQ-014 The FSM SHALL have three states:
- IDLE: no request.
- FETCH: mem_req=1, mem_addr=pc.
- HOLD: fetched word buffered; mem_req=0.
REQ-015 IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-016 In FETCH, pc SHALL NOT change until the cycle mem_ready=1.
REQ-017 FETCH, mem_ready=1, stall=0, no redirect pending, br=0:
- if_inst<=mem_rdata, if_pc<=pc, if_valid<=1.
- pc<=pc+4 (mod 2^32).
- Stay in FETCH; the next request is issued the following cycle.
REQ-018 FETCH, mem_ready=1, stall=1, no redirect pending:
- Capture mem_rdata/pc into buf_inst/buf_pc.
- pc<=pc+4; go to HOLD.
- Output registers unchanged.
REQ-019 FETCH, mem_ready=0, stall=0, br=0: if_inst<=32'h0000_0013 (NOP), if_valid<=0 (bubble).
REQ-020 HOLD, stall=0, br=0: if_inst<=buf_inst, if_pc<=buf_pc, if_valid<=1; go to FETCH.
REQ-021 br SHALL be honoured only when stall=0.
REQ-022 On an honoured br, the output SHALL become a bubble next cycle (NOP, valid 0).
REQ-023 br in FETCH with mem_ready=0: set redirect_pending, latch redirect_pc<=br_addr; the request continues unchanged.
REQ-024 FETCH with mem_ready=1 and (redirect_pending or honoured br):
- Discard mem_rdata.
- pc<=latched target, or br_addr if br=1 this cycle (br_addr wins).
- Clear redirect_pending; stay in FETCH.
REQ-025 HOLD with honoured br: discard the buffer, pc<=br_addr, go to FETCH.
REQ-026 mem_req SHALL be 0 in any cycle where rst=1.

Reset
REQ-027 On rst the block SHALL set:
- state=IDLE, pc=RESET_PC.
- if_pc=0, if_inst=NOP, if_valid=0.
- redirect_pending=0, buf_inst=NOP, buf_pc=0.
REQ-028 rst mid-request SHALL abandon the request; the memory ignores an uncompleted request once mem_req drops.

Structure
REQ-029 The NOP encoding, InstAddrBus/InstBus widths and RESET_PC default SHALL live in the shared defines file.
REQ-030 FSM state encodings SHALL be local to stage_if.
REQ-031 No sub-module is required; the skid buffer SHALL be inline.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Zero-wait memory, stall=0, words at 0,4,8: if_pc 0,4,8 on consecutive cycles, if_valid=1 from the 3rd cycle after rst falls.
- mem_ready after 3 wait cycles at addr 0x10: mem_addr stays 0x10 for 4 cycles; if_valid=0 during the wait; then if_inst=mem_rdata, if_pc=0x10.
- stall=1 for 2 cycles while mem_ready=1 at 0x20: outputs hold; word buffered; on stall=0, if_pc=0x20 valid; next fetch is 0x24.
- br=1, br_addr=0x100 while a fetch at 0x8 is pending for 2 more cycles: 0x8 data discarded; if_valid=0 until the word from 0x100 arrives; next mem_addr=0x100.
- br=1, br_addr=0x40 in the same cycle as mem_ready: data dropped; next mem_addr=0x40.
- rst asserted mid-request: mem_req=0 while rst=1; after release, the first mem_addr is RESET_PC and all outputs are at reset values.
